// File: rtl/score_disp_pkg.sv
// Shared types and constants for the packed-BCD score display scanner.
package score_disp_pkg;

  typedef logic [6:0] seg_t;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

  function automatic int unsigned digit_idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment decoder; A-F decode to a dash and raise err.
module bcd_to_seg7
  import score_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output seg_t       o_seg_c,
  output logic       o_err_c
);

  always_comb begin
    o_seg_c = SEG_OFF;
    o_err_c = 1'b0;
    if (!i_blank) begin
      case (i_nibble)
        4'd0:    o_seg_c = SEG_0;
        4'd1:    o_seg_c = SEG_1;
        4'd2:    o_seg_c = SEG_2;
        4'd3:    o_seg_c = SEG_3;
        4'd4:    o_seg_c = SEG_4;
        4'd5:    o_seg_c = SEG_5;
        4'd6:    o_seg_c = SEG_6;
        4'd7:    o_seg_c = SEG_7;
        4'd8:    o_seg_c = SEG_8;
        4'd9:    o_seg_c = SEG_9;
        default: begin
          o_seg_c = SEG_DASH;
          o_err_c = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/score_display_scan.sv
// Time-multiplexed 7-segment scanner for the packed-BCD score bus.
// The score is snapshotted only at frame wrap so a frame never shows a torn value.
module score_display_scan
  import score_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned PRESCALE       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] score_bcd,
  input  logic                    en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_done,
  output logic                    digit_err
);

  localparam int unsigned IDX_W = digit_idx_w(NUM_DIGITS);
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [NUM_DIGITS-1:0] AN_MASK  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_MASK = {7{SEG_ACTIVE_LOW}};

  logic [PRE_W-1:0]        r_prescale;
  logic [IDX_W-1:0]        r_index;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_frame_done;
  logic                    r_digit_err;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nibble;
  logic                    w_blank;
  seg_t                    w_code;
  logic                    w_err;
  logic [NUM_DIGITS-1:0]   w_an_sel;

  assign w_tick   = en && (r_prescale == PRE_W'(PRESCALE - 1));
  assign w_wrap   = w_tick && (r_index == IDX_W'(NUM_DIGITS - 1));
  assign w_an_sel = NUM_DIGITS'(1) << r_index;

  // Current digit nibble, and leading-zero blank: this digit and all above it are zero
  always_comb begin
    w_nibble = 4'd0;
    w_blank  = (r_index != '0);
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      if (r_index == IDX_W'(j)) w_nibble = r_shadow[4*j +: 4];
      if ((IDX_W'(j) >= r_index) && (r_shadow[4*j +: 4] != 4'd0)) w_blank = 1'b0;
    end
  end

  bcd_to_seg7 u_dec (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg_c  (w_code),
    .o_err_c  (w_err)
  );

  // Scan timebase and frame snapshot
  always_ff @(posedge clk) begin
    if (clr) begin
      r_prescale <= '0;
      r_index    <= '0;
      r_shadow   <= '0;
    end else if (en) begin
      r_prescale <= w_tick ? '0 : r_prescale + PRE_W'(1);
      if (w_tick) r_index <= w_wrap ? '0 : r_index + IDX_W'(1);
      if (w_wrap) r_shadow <= score_bcd;
    end
  end

  // Output registers; polarity applied here only
  always_ff @(posedge clk) begin
    if (clr) begin
      r_an         <= AN_MASK;
      r_seg        <= SEG_MASK;
      r_frame_done <= 1'b0;
      r_digit_err  <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (en && !w_blank) begin
        r_an  <= w_an_sel ^ AN_MASK;
        r_seg <= w_code ^ SEG_MASK;
      end else begin
        r_an  <= AN_MASK;
        r_seg <= SEG_MASK;
      end
      if (en && w_err) r_digit_err <= 1'b1;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;
  assign digit_err  = r_digit_err;

endmodule

// File: tb/tb_score_display_scan.sv
// Randomized self-checking bench for score_display_scan against a count-based display model.
module tb_score_display_scan;

  localparam int ND  = 8;
  localparam int PS  = 4;
  localparam int FRM = ND * PS;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          en  = 1'b1;
  logic [31:0]   score_bcd = '0;
  logic [7:0]    an;
  logic [6:0]    seg;
  logic          frame_done;
  logic          digit_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: enabled-edge count since reset drives the scan position
  int          m_n      = 0;
  logic [31:0] m_shadow = '0;
  logic [7:0]  m_an     = 8'hFF;
  logic [6:0]  m_seg    = 7'h7F;
  logic        m_fd     = 1'b0;
  logic        m_err    = 1'b0;

  localparam logic [6:0] REF_SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  score_display_scan #(
    .NUM_DIGITS     (ND),
    .PRESCALE       (PS),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .score_bcd  (score_bcd),
    .en         (en),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .digit_err  (digit_err)
  );

  // Pin levels for digit idx of a shown number
  task automatic ref_digit(input logic [31:0] sh, input int idx,
                           output logic [7:0] a, output logic [6:0] s, output logic e);
    logic [3:0] d;
    d = 4'(sh >> (4 * idx));
    e = 1'b0;
    if (idx != 0 && (sh >> (4 * idx)) == 32'd0) begin
      a = 8'hFF;
      s = 7'h7F;
    end else begin
      a = ~(8'h01 << idx);
      if (d > 4'd9) begin
        s = ~7'h40;
        e = 1'b1;
      end else begin
        s = ~REF_SEG[d];
      end
    end
  endtask

  task automatic tick();
    logic [7:0] a;
    logic [6:0] s;
    logic       e;
    @(posedge clk);
    if (clr) begin
      m_n = 0; m_shadow = '0; m_an = 8'hFF; m_seg = 7'h7F; m_fd = 1'b0; m_err = 1'b0;
    end else begin
      m_fd = 1'b0;
      if (en) begin
        ref_digit(m_shadow, (m_n / PS) % ND, a, s, e);
        m_an = a; m_seg = s;
        if (e) m_err = 1'b1;
        if (m_n % FRM == FRM - 1) begin
          m_shadow = score_bcd;
          m_fd     = 1'b1;
        end
        m_n++;
      end else begin
        m_an = 8'hFF; m_seg = 7'h7F;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; clr = 1'b1; score_bcd = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({an, seg, frame_done, digit_err} !== {8'hFF, 7'h7F, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset cyc%0d: an=%h seg=%h fd=%b err=%b, want an=ff seg=7f fd=0 err=0",
                 i, an, seg, frame_done, digit_err);
      end
    end
    clr = 1'b0;
    tick();
    n_checks++;
    if ({an, seg} !== {8'hFE, 7'h40}) begin
      n_fail++;
      $display("FAIL reset_release: an=%h seg=%h, want an=fe seg=40", an, seg);
    end
  endtask

  task automatic test_scan_1234();
    int last_fd = -1;
    score_bcd = 32'h0000_1234;
    for (int c = 0; c < 3 * FRM + 8; c++) begin
      tick();
      n_checks++;
      if ({an, seg, frame_done, digit_err} !== {m_an, m_seg, m_fd, m_err}) begin
        n_fail++;
        $display("FAIL scan_1234 c%0d: an=%h seg=%h fd=%b err=%b, want %h %h %b %b",
                 c, an, seg, frame_done, digit_err, m_an, m_seg, m_fd, m_err);
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          n_checks++;
          if (c - last_fd !== FRM) begin
            n_fail++;
            $display("FAIL frame_period: got %0d cycles, want %0d", c - last_fd, FRM);
          end
        end
        last_fd = c;
      end
    end
  endtask

  task automatic test_midframe_change();
    int  guard = 0;
    bit  seen  = 0;
    while (m_n % FRM != 10 && guard < 2 * FRM) begin tick(); guard++; end
    score_bcd = 32'h0000_9999;
    for (int c = 0; c < 2 * FRM; c++) begin
      tick();
      n_checks++;
      if ({an, seg, frame_done} !== {m_an, m_seg, m_fd}) begin
        n_fail++;
        $display("FAIL midframe c%0d: an=%h seg=%h fd=%b, want %h %h %b",
                 c, an, seg, frame_done, m_an, m_seg, m_fd);
      end
      if (frame_done && !seen) begin
        seen = 1;
        tick();
        n_checks++;
        if ({an, seg} !== {8'hFE, 7'h10}) begin
          n_fail++;
          $display("FAIL after_snapshot: an=%h seg=%h, want an=fe seg=10", an, seg);
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midframe_fd: no frame_done within %0d cycles", 2 * FRM);
    end
  endtask

  task automatic test_zero();
    int lit = 0;
    score_bcd = 32'h0;
    for (int c = 0; c < 3 * FRM; c++) begin
      tick();
      n_checks++;
      if ({an, seg, frame_done} !== {m_an, m_seg, m_fd}) begin
        n_fail++;
        $display("FAIL zero c%0d: an=%h seg=%h fd=%b, want %h %h %b",
                 c, an, seg, frame_done, m_an, m_seg, m_fd);
      end
      if (c >= 2 * FRM && an !== 8'hFF) lit++;
    end
    n_checks++;
    if (lit !== PS) begin
      n_fail++;
      $display("FAIL zero_lit: lit cycles per frame %0d, want %0d", lit, PS);
    end
  endtask

  task automatic test_digit_err();
    clr = 1'b1; tick(); clr = 1'b0;
    score_bcd = 32'h0000_0C00;
    for (int c = 0; c < 3 * FRM; c++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_err} !== {m_an, m_seg, m_err}) begin
        n_fail++;
        $display("FAIL digit_err c%0d: an=%h seg=%h err=%b, want %h %h %b",
                 c, an, seg, digit_err, m_an, m_seg, m_err);
      end
    end
    score_bcd = 32'h0000_0001;
    for (int c = 0; c < 2 * FRM; c++) tick();
    n_checks++;
    if (digit_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: digit_err=%b, want 1", digit_err);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    n_checks++;
    if (digit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: digit_err=%b, want 0", digit_err);
    end
  endtask

  task automatic test_enable_pause();
    int guard = 0;
    int edges = 0;
    score_bcd = 32'h8765_4321;
    while (m_n % FRM != 14 && guard < 2 * FRM) begin tick(); guard++; end
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({an, seg, frame_done} !== {8'hFF, 7'h7F, 1'b0}) begin
        n_fail++;
        $display("FAIL paused c%0d: an=%h seg=%h fd=%b, want ff 7f 0", c, an, seg, frame_done);
      end
    end
    en = 1'b1;
    do begin
      tick();
      edges++;
      n_checks++;
      if ({an, seg} !== {m_an, m_seg}) begin
        n_fail++;
        $display("FAIL resume e%0d: an=%h seg=%h, want %h %h", edges, an, seg, m_an, m_seg);
      end
    end while (!frame_done && edges < 2 * FRM);
    n_checks++;
    if (edges !== 18) begin
      n_fail++;
      $display("FAIL resume_period: frame_done after %0d edges, want 18", edges);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        int k;
        k = $urandom_range(0, ND);
        score_bcd = '0;
        for (int d = 0; d < k; d++)
          score_bcd[4*d +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                             : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) en = ~en;
      tick();
      n_checks++;
      if ({an, seg, frame_done, digit_err} !== {m_an, m_seg, m_fd, m_err}) begin
        n_fail++;
        $display("FAIL random c%0d: an=%h seg=%h fd=%b err=%b, want %h %h %b %b",
                 c, an, seg, frame_done, digit_err, m_an, m_seg, m_fd, m_err);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_midframe_change();
    test_zero();
    test_digit_err();
    test_enable_pause();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
